usb_pid_decoder: RTL

Parametrised successor to the team's USB packet-ID checker. Deserialises the 8-bit PID field from the de-stuffed receive bit stream and checks the complement nibble against a configurable set of accepted PIDs. Reports the decoded 4-bit PID and its class (token/data/handshake/special) plus per-cause error flags, and keeps a saturating error count. Sits between the bit-unstuffer and the packet-level receive FSM.

---
 rtl/usb_pid_decoder_pkg.sv | 35 +++
 rtl/usb_pid_decoder_if.sv | 38 +++
 rtl/usb_pid_decoder_sat_counter.sv | 20 ++
 rtl/usb_pid_decoder.sv | 115 +++++++++++
 4 files changed

// File: rtl/usb_pid_decoder_pkg.sv
// Shared USB receive-path definitions: PID class and code constants, PID
// decoder FSM states, and the complement-nibble check.
package usb_pkg;

    typedef enum logic [1:0] {
        PT_SPECIAL   = 2'b00,
        PT_TOKEN     = 2'b01,
        PT_HANDSHAKE = 2'b10,
        PT_DATA      = 2'b11
    } pid_type_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_PRE   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        HOLD_OK  = 2'd2,
        HOLD_ERR = 2'd3
    } pid_state_t;

    // The upper nibble of a PID byte carries the one's complement of the code.
    function automatic logic pid_complement_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_pid_decoder_if.sv
// Signal bundle between the bit-unstuffer / packet FSM (master) and the PID
// decoder (slave).
interface usb_pid_if #(
    parameter int CNT_W = 8
);
    import usb_pkg::*;

    // Handshake: s_in is consumed only in cycles where bit_valid is high; there
    // is no backpressure. start_decode marks the first bit and must coincide
    // with bit_valid. A decode result is held (pid_checked) until end_pid.
    logic             start_decode;
    logic             s_in;
    logic             bit_valid;
    logic             end_pid;
    logic             cnt_clr;
    logic             pid_checked;
    logic             pid_valid;
    logic [3:0]       pid_code;
    pid_type_t        pid_type;
    logic             err_complement;
    logic             err_unsupported;
    logic             err_truncated;
    logic [CNT_W-1:0] err_count;
    pid_state_t       dbg_state;

    modport master (
        output start_decode, s_in, bit_valid, end_pid, cnt_clr,
        input  pid_checked, pid_valid, pid_code, pid_type, err_complement,
               err_unsupported, err_truncated, err_count, dbg_state
    );

    modport slave (
        input  start_decode, s_in, bit_valid, end_pid, cnt_clr,
        output pid_checked, pid_valid, pid_code, pid_type, err_complement,
               err_unsupported, err_truncated, err_count, dbg_state
    );

endinterface

// File: rtl/usb_pid_decoder_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_pid_decoder.sv
// Deserialises the 8-bit USB PID field, checks the complement nibble and the
// accepted-code mask, and holds the registered result until end_pid.
module usb_pid_decoder
    import usb_pkg::*;
#(
    parameter logic [15:0] ALLOWED_MASK = 16'hFFFE,
    parameter int          CNT_W        = 8
) (
    input logic       clk,
    input logic       rst,
    usb_pid_if.slave  bus
);

    pid_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_q, byte_d;

    logic       checked_q, checked_d;
    logic       valid_q, valid_d;
    logic [3:0] code_q, code_d;
    logic       ecomp_q, ecomp_d;
    logic       eunsup_q, eunsup_d;
    logic       etrunc_q, etrunc_d;
    logic       err_event;

    // State register; every output is registered here as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            byte_q    <= 8'd0;
            checked_q <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
            ecomp_q   <= 1'b0;
            eunsup_q  <= 1'b0;
            etrunc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            checked_q <= checked_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ecomp_q   <= ecomp_d;
            eunsup_q  <= eunsup_d;
            etrunc_q  <= etrunc_d;
        end
    end

    // Next state; end_pid in SHIFT aborts even if it coincides with the last bit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_decode && bus.bit_valid) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 4'd1;
                    byte_d    = {7'd0, bus.s_in};
                end
            end
            SHIFT: begin
                if (bus.end_pid) begin
                    state_d   = IDLE;
                    bit_cnt_d = 4'd0;
                end else if (bus.bit_valid) begin
                    byte_d[bit_cnt_q[2:0]] = bus.s_in;
                    bit_cnt_d              = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = (pid_complement_ok(byte_d) && ALLOWED_MASK[byte_d[3:0]])
                                  ? HOLD_OK : HOLD_ERR;
                    end
                end
            end
            HOLD_OK, HOLD_ERR: begin
                if (bus.end_pid) begin
                    state_d   = IDLE;
                    bit_cnt_d = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the transition taken.
    always_comb begin
        checked_d = (state_d == HOLD_OK) || (state_d == HOLD_ERR);
        valid_d   = (state_d == HOLD_OK);
        code_d    = checked_d ? byte_d[3:0] : 4'd0;
        ecomp_d   = (state_d == HOLD_ERR) && !pid_complement_ok(byte_d);
        eunsup_d  = (state_d == HOLD_ERR) && pid_complement_ok(byte_d);
        etrunc_d  = (state_q == SHIFT) && bus.end_pid;
        err_event = etrunc_d || ((state_q == SHIFT) && (state_d == HOLD_ERR));
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.cnt_clr),
        .en    (err_event),
        .count (bus.err_count)
    );

    assign bus.pid_checked     = checked_q;
    assign bus.pid_valid       = valid_q;
    assign bus.pid_code        = code_q;
    assign bus.pid_type        = pid_type_t'(code_q[1:0]);
    assign bus.err_complement  = ecomp_q;
    assign bus.err_unsupported = eunsup_q;
    assign bus.err_truncated   = etrunc_q;
    assign bus.dbg_state       = state_q;

endmodule
